// File: rtl/bocks_fb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bocks_fb_pkg : framebuffer geometry, bus widths and write-arbiter state codes
// Rev 1.0
// ---------------------------------------------------------------------------
package bocks_fb_pkg;

    localparam int PIXEL_WIDTH  = 640;
    localparam int PIXEL_HEIGHT = 400;
    localparam int PIXEL_COUNT  = PIXEL_WIDTH * PIXEL_HEIGHT;

    localparam int FB_ADDR_W = 32;
    localparam int FB_DATA_W = 8;

    // Requester index width; covers up to four producers.
    localparam int ID_W = 2;

    typedef enum logic [0:0] {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

    function automatic logic [ID_W-1:0] rr_wrap(
        input logic [ID_W-1:0] base,
        input int unsigned     step,
        input int unsigned     n
    );
        int unsigned sum;
        sum = (32'(base) + step) % n;
        return sum[ID_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_rr_pick : round-robin winner search starting just after i_ptr, with wrap
// Rev 1.0
// ---------------------------------------------------------------------------
module fb_rr_pick
    import bocks_fb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_found,
    output logic [ID_W-1:0]    o_idx
);

    logic [3:0]      w_valid4;
    logic [ID_W-1:0] w_cand;

    assign w_valid4 = 4'(i_valid);

    // Scan farthest-first so the nearest valid candidate is the last writer.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = rr_wrap(i_ptr, $unsigned(k), $unsigned(NUM_REQ));
            if (w_valid4[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_write_arbiter : round-robin, burst-locked sharing of the vga write port
// Rev 1.0
// ---------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = bocks_fb_pkg::FB_ADDR_W,
    parameter int DATA_W       = bocks_fb_pkg::FB_DATA_W,
    parameter int PIXEL_COUNT  = bocks_fb_pkg::PIXEL_COUNT,
    parameter int BURST_MAX    = 16,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cpu_wr,
    output logic [ADDR_W-1:0]         cpu_addr,
    output logic [DATA_W-1:0]         cpu_data,
    output logic [1:0]                grant_id,
    output logic                      busy,
    output logic [15:0]               err_cnt
);

    import bocks_fb_pkg::*;

    localparam int                 c_BC_W         = $clog2(BURST_MAX + 1);
    localparam int                 c_IC_W         = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [c_BC_W-1:0]  c_BURST_MAX    = c_BC_W'(BURST_MAX);
    localparam logic [c_IC_W-1:0]  c_IDLE_TIMEOUT = c_IC_W'(IDLE_TIMEOUT);
    localparam logic [ADDR_W-1:0]  c_PIX_LIMIT    = ADDR_W'(PIXEL_COUNT);
    localparam logic [ID_W-1:0]    c_PTR_INIT     = ID_W'(NUM_REQ - 1);

    arb_state_t        r_state;
    logic [ID_W-1:0]   r_grant;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [c_BC_W-1:0] r_beat_cnt;
    logic [c_IC_W-1:0] r_idle_cnt;
    logic              r_cpu_wr;
    logic [ADDR_W-1:0] r_cpu_addr;
    logic [DATA_W-1:0] r_cpu_data;
    logic [15:0]       r_err_cnt;

    logic [NUM_REQ-1:0] w_grant_oh;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_own;
    logic               w_accept;
    logic               w_others;
    logic               w_in_range;
    logic [c_BC_W-1:0]  w_beat_next;
    logic [c_IC_W-1:0]  w_idle_next;
    logic               w_release;
    logic               w_pick_found;
    logic [ID_W-1:0]    w_pick_idx;

    fb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_grant_oh  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_grant_oh[i] = 1'b1;
                w_sel_valid   = req_valid[i];
                w_sel_last    = req_last[i];
                w_sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data    = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_own       = (r_state == OWN);
    assign req_ready   = w_own ? w_grant_oh : '0;
    assign w_accept    = w_own && w_sel_valid;
    assign w_others    = |(req_valid & ~w_grant_oh);
    assign w_in_range  = (w_sel_addr < c_PIX_LIMIT);
    assign w_beat_next = (r_beat_cnt == c_BURST_MAX) ? r_beat_cnt : r_beat_cnt + c_BC_W'(1);
    assign w_idle_next = r_idle_cnt + c_IC_W'(1);

    // Any one of last-beat, burst cap under contention, or idle timeout ends ownership.
    assign w_release = w_accept ? (w_sel_last || ((w_beat_next == c_BURST_MAX) && w_others))
                                : (w_idle_next == c_IDLE_TIMEOUT);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB;
            r_grant    <= '0;
            r_rr_ptr   <= c_PTR_INIT;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_cpu_wr   <= 1'b0;
            r_cpu_addr <= '0;
            r_cpu_data <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_cpu_wr <= 1'b0;
            case (r_state)
                ARB: begin
                    if (w_pick_found) begin
                        r_grant    <= w_pick_idx;
                        r_rr_ptr   <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_idle_cnt <= '0;
                        r_state    <= OWN;
                    end
                end
                OWN: begin
                    if (w_accept) begin
                        r_cpu_addr <= w_sel_addr;
                        r_cpu_data <= w_sel_data;
                        r_cpu_wr   <= w_in_range;
                        if (!w_in_range && (r_err_cnt != 16'hFFFF)) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                        r_beat_cnt <= w_beat_next;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= w_idle_next;
                    end
                    if (w_release) begin
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign cpu_wr   = r_cpu_wr;
    assign cpu_addr = r_cpu_addr;
    assign cpu_data = r_cpu_data;
    assign grant_id = r_grant;
    assign busy     = w_own;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
Shares the single framebuffer write port of the vga block (cpu_wr/cpu_addr/cpu_data) among several pixel producers, such as the font glyph blitter, a screen-clear engine and a text cursor renderer.
- Arbitration is round-robin, with burst locking so a glyph row lands contiguously.
- A starvation limit forces rotation; an idle timeout releases a stalled owner.
- Out-of-range writes are blocked and counted.
- It sits between the producers and the vga instance inside bocks_top.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
ADDR_W, 32, framebuffer address width
DATA_W, 8, pixel data width
PIXEL_COUNT, 256000, framebuffer size (640*400); valid addresses are 0..PIXEL_COUNT-1
BURST_MAX, 16, beats a requester may hold the port while another requester is waiting
IDLE_TIMEOUT, 8, consecutive cycles the owner may hold valid low before its grant is revoked

Ports:
pclk  in  1  clock (pixel clock, also the write clock)
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  beat is the final beat of the requester's burst
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed pixel data
req_ready  out  NUM_REQ  beat accepted this cycle when valid&ready
cpu_wr  out  1  to vga cpu_wr
cpu_addr  out  ADDR_W  to vga cpu_addr
cpu_data  out  DATA_W  to vga cpu_data
grant_id  out  2  index of current/last owner
busy  out  1  high while in the OWN state
err_cnt  out  16  saturating count of dropped out-of-range beats

Behaviour:
- Reset values (asynchronous, take effect immediately even mid-burst):
  - cpu_wr=0, cpu_addr=0, cpu_data=0.
  - grant_id=0, busy=0, err_cnt=0.
  - state=ARB; rr_ptr=NUM_REQ-1, so requester 0 wins first.
- States:
  - ARB: one bubble cycle. Pick the first i with req_valid[i], scanning from rr_ptr+1 upward with wrap. If one is found, set grant_id=i, rr_ptr=i, beat_cnt=0, idle_cnt=0 and go to OWN. If none, stay in ARB.
  - OWN: req_ready[grant_id]=1 combinationally; every other req_ready is 0. In ARB all req_ready are 0.
- Beat transfer in OWN (req_valid[g]&&req_ready[g]), with 1-cycle latency:
  - Next cycle cpu_addr/cpu_data = the beat's address/data.
  - cpu_wr=1 only if addr<PIXEL_COUNT.
  - Otherwise cpu_wr=0 and err_cnt increments, saturating at 16'hFFFF.
  - cpu_wr is 0 on every cycle without an accepted beat. cpu_addr/cpu_data hold their last value.
- beat_cnt increments on each accepted beat; idle_cnt increments on each OWN cycle with owner valid low and clears on a valid cycle.
- Release OWN to ARB (after this cycle's beat, if any) when any of these holds:
  - the accepted beat has req_last=1;
  - the accepted beat makes beat_cnt reach BURST_MAX while some other req_valid[j]=1 that cycle;
  - idle_cnt reaches IDLE_TIMEOUT.
- Simultaneous conditions release once; no double bubble.
- With no competitor, the BURST_MAX limit is ignored; beat_cnt saturates.
- A released requester keeps its un-ended burst state externally and re-arbitrates normally.
- Fairness: after release, rr_ptr=owner, so the owner has lowest priority next ARB.
- Sustained throughput: one beat per cycle within a burst; one dead cycle per grant change.
- Width rules:
  - beat_cnt and idle_cnt are sized by $clog2(max+1).
  - Address compare is unsigned, full ADDR_W.
  - grant_id upper bits are 0 when NUM_REQ<4.

Decomposition:
- Package bocks_fb_pkg holds:
  - PIXEL_WIDTH=640, PIXEL_HEIGHT=400, PIXEL_COUNT=256000;
  - FB_ADDR_W=32, FB_DATA_W=8;
  - arbiter state encoding (ARB=1'b0, OWN=1'b1).
- One combinational sub-module, fb_rr_pick: inputs are the valid vector and rr_ptr; outputs are found and the winner index. It is reused by future palette/blit arbiters.

Test Plan:
- Reset, then req0 valid with a 4-beat burst at addr 0..3 and data FF,00,FF,00, last on beat 4 -> ARB bubble, then four consecutive cpu_wr pulses, addr 0..3, data matches, then back to ARB. err_cnt=0.
- req0 and req2 both valid continuously with long bursts, BURST_MAX=16 -> req0 gets exactly 16 beats, 1 bubble, then req2 gets 16, then req0. grant_id alternates 0,2,0.
- Single requester req1 with a 40-beat burst, no competitor -> 40 contiguous beats, no forced rotation.
- Owner req0 drops valid after 2 beats for 8 cycles while req1 waits -> grant revoked on the 8th idle cycle; req1 owns after one bubble.
- req1 beat with addr=256000, then addr=255999 -> first beat gives cpu_wr=0 and err_cnt=1; second gives cpu_wr=1 and cpu_addr=255999. Preload err_cnt at FFFF via 65535 bad beats, send one more -> err_cnt stays at FFFF.
- Assert reset mid-burst on cycle 3 of OWN -> cpu_wr drops in the same cycle (async). After release, req0 wins first even if req2 is also valid.
